// File: rtl/control_issue.sv
// rtl/control_issue.sv - decode-and-issue stage: instruction FIFO, control decoder, multi-cycle stall, HALT
// Optional illegal-opcode trap: define CONTROL_ISSUE_ILLEGAL_TRAP_EN

package control_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef enum logic [2:0] {
    R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, HALT_TYPE
  } encoding_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  typedef struct packed {
    encoding_t  encoding;
    alu_op_t    alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [4:0] write_back_id;
  } control_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_HALT = 7'b1111111;

endpackage

module control
  import control_issue_pkg::*;
(
  input  instruction_t instr,
  output control_t     ctrl
);

  logic unused_fields;
  assign unused_fields = ^{instr.rs1, instr.rs2, instr.funct7};

  // alt selects SUB/SRA; SUB only exists for register-register ops
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      3'd0:    return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl = '0;
    ctrl.write_back_id = instr.rd;
    case (instr.opcode)
      OP_R: begin
        ctrl.encoding  = R_TYPE;
        ctrl.reg_write = 1'b1;
        if (instr.funct7 == 7'b0000001) begin
          case (instr.funct3)
            3'd0:              ctrl.alu_op = ALU_MUL;
            3'd1, 3'd2, 3'd3:  ctrl.alu_op = ALU_MULH;
            3'd4:              ctrl.alu_op = ALU_DIV;
            3'd5:              ctrl.alu_op = ALU_DIVU;
            3'd6:              ctrl.alu_op = ALU_REM;
            default:           ctrl.alu_op = ALU_REMU;
          endcase
        end else begin
          ctrl.alu_op = alu_from_f3(instr.funct3, instr.funct7[5], 1'b1);
        end
      end
      OP_I: begin
        ctrl.encoding  = I_TYPE;
        ctrl.alu_op    = alu_from_f3(instr.funct3, instr.funct7[5], 1'b0);
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_S: begin
        ctrl.encoding  = S_TYPE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_B: begin
        ctrl.encoding = B_TYPE;
        ctrl.alu_op   = ALU_SUB;
        ctrl.branch   = 1'b1;
      end
      OP_LUI: begin
        ctrl.encoding  = U_TYPE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_JAL: begin
        ctrl.encoding  = J_TYPE;
        ctrl.alu_op    = ALU_ADD;
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
      end
      OP_LOAD: begin
        ctrl.encoding   = I_TYPE;
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_HALT: begin
        ctrl.encoding = HALT_TYPE;
      end
      default: begin
        ctrl.encoding  = I_TYPE;
        ctrl.alu_op    = ALU_AND;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
    endcase
  end

endmodule

module control_issue
  import control_issue_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output control_t        out_control,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  output logic            mc_busy,
  output logic            halted
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int MCW = $clog2(DIV_CYCLES + 1);
  localparam bit MC_EN = (DIV_CYCLES > 1);

  typedef enum logic [1:0] {RUN, MC_WAIT, HALTED} state_t;

  state_t          state;
  logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [MCW-1:0]  mc_count;

  logic            full, empty, push, pop, load, load_slot;
  logic            handshake, is_div, hs_div, hs_halt;
  logic [XLEN-1:0] head_instr, head_pc;
  instruction_t    head_fields;
  control_t        dec_ctrl, issue_ctrl;
  logic            head_illegal;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  assign in_ready = rst_n && !full && !flush && (state != HALTED);
  assign push     = in_valid && in_ready;

  assign head_instr  = fifo_instr[rd_ptr];
  assign head_pc     = fifo_pc[rd_ptr];
  assign head_fields = head_instr[31:0];

  control u_control (
    .instr (head_fields),
    .ctrl  (dec_ctrl)
  );

`ifdef CONTROL_ISSUE_ILLEGAL_TRAP_EN
  always_comb begin
    issue_ctrl   = dec_ctrl;
    head_illegal = 1'b0;
    case (head_fields.opcode)
      OP_R, OP_I, OP_S, OP_B, OP_LUI, OP_JAL, OP_LOAD, OP_HALT: head_illegal = 1'b0;
      default:                                                   head_illegal = 1'b1;
    endcase
    // an illegal word must not write the register file; keep only rd for trap reporting
    if (head_illegal) begin
      issue_ctrl = '0;
      issue_ctrl.write_back_id = dec_ctrl.write_back_id;
    end
  end
`else
  assign issue_ctrl   = dec_ctrl;
  assign head_illegal = 1'b0;
`endif

  assign handshake = out_valid && out_ready;
  assign is_div    = out_control.alu_op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign hs_div    = handshake && MC_EN && is_div;
  assign hs_halt   = handshake && (out_control.encoding == HALT_TYPE || out_illegal);

  // the stall's final cycle also refills the output register so the next word follows immediately
  assign load_slot = !flush &&
                     ((state == RUN && !hs_div && !hs_halt) ||
                      (state == MC_WAIT && mc_count == MCW'(1)));
  assign load      = load_slot && !empty && (!out_valid || out_ready);
  assign pop       = load;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= in_instr;
      fifo_pc[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush && state != HALTED) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      mc_count    <= '0;
      mc_busy     <= 1'b0;
      halted      <= 1'b0;
      out_valid   <= 1'b0;
      out_control <= '0;
      out_instr   <= '0;
      out_pc      <= '0;
      out_illegal <= 1'b0;
    end else if (state != HALTED) begin
      if (flush) begin
        state     <= RUN;
        mc_count  <= '0;
        mc_busy   <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        if (state == MC_WAIT) begin
          if (mc_count == MCW'(1)) begin
            state    <= RUN;
            mc_busy  <= 1'b0;
            mc_count <= '0;
          end else begin
            mc_count <= mc_count - 1'b1;
          end
        end
        if (handshake) begin
          out_valid <= 1'b0;
          if (hs_halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else if (hs_div) begin
            state    <= MC_WAIT;
            mc_count <= MCW'(DIV_CYCLES - 1);
            mc_busy  <= 1'b1;
          end
        end
        if (load) begin
          out_valid   <= 1'b1;
          out_control <= issue_ctrl;
          out_instr   <= head_instr;
          out_pc      <= head_pc;
          out_illegal <= head_illegal;
        end
      end
    end
  end

endmodule
